mem_channel_arbiter: RTL and testbench

Parametrised multi-channel memory arbiter between NUM_CONSUMERS requesters (LSUs or fetchers) and NUM_CHANNELS memory channels, for both data memory and program memory.

- Each channel runs its own request/response state machine and holds one transaction until memory completes it.
- Grants rotate round-robin across consumers, and a consumer is never served by two channels at once.
- WRITE_ENABLE selects a read/write data-memory port or a read-only program-memory port.

---
 rtl/mem_channel_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_channel_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter: round-robin arbiter that maps NUM_CONSUMERS read/write
// requesters onto NUM_CHANNELS memory channels. Each channel owns one
// transaction at a time. A consumer is never served by two channels at once.
//
// Handshake: a consumer raises *_valid and holds it, with stable address and
// data, until it sees a one-cycle *_ready strobe. It must then drop valid
// before the owning channel returns to IDLE. Toward memory, mem_*_valid is
// registered and held stable until mem_*_ready is sampled high. mem_*_ready is
// ignored while the channel is not waiting on memory.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1,
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_write_address,
    input  logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]              mem_read_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
    input  logic [DATA_BITS*NUM_CHANNELS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]              mem_write_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]    mem_write_address,
    output logic [DATA_BITS*NUM_CHANNELS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]              mem_write_ready,
    output logic [2*NUM_CHANNELS-1:0]            dbg_chan_state,
    output logic [CW-1:0]                        dbg_rr_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2,
        ST_RELEASE    = 2'd3
    } chan_state_t;

    chan_state_t                  state_q    [NUM_CHANNELS];
    chan_state_t                  state_d    [NUM_CHANNELS];
    logic [CW-1:0]                owner_q    [NUM_CHANNELS];
    logic [CW-1:0]                owner_d    [NUM_CHANNELS];
    logic                         is_write_q [NUM_CHANNELS];
    logic                         is_write_d [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]         addr_q     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]         addr_d     [NUM_CHANNELS];
    logic [DATA_BITS-1:0]         wdata_q    [NUM_CHANNELS];
    logic [DATA_BITS-1:0]         wdata_d    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]      mem_rv_q, mem_rv_d;
    logic [NUM_CHANNELS-1:0]      mem_wv_q, mem_wv_d;
    logic [CW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [NUM_CONSUMERS-1:0]     rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]     wr_ready_q, wr_ready_d;
    logic [DATA_BITS*NUM_CONSUMERS-1:0] rd_data_q, rd_data_d;

    logic [NUM_CONSUMERS-1:0]     busy;
    logic [NUM_CONSUMERS-1:0]     granted;
    logic [NUM_CONSUMERS-1:0]     wr_req;
    logic                         found;
    int                           idx;
    logic [CW-1:0]                cand;

    // Write requests only exist on the read/write variant.
    assign wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    // Busy mask: a consumer owned by any non-idle channel cannot be granted again.
    always_comb begin
        busy = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] != ST_IDLE) busy[owner_q[c]] = 1'b1;
        end
    end

    // Arbitration and per-channel next state; idle channels pick in index order.
    always_comb begin
        granted    = '0;
        found      = 1'b0;
        idx        = 0;
        cand       = '0;
        rr_ptr_d   = rr_ptr_q;
        rd_ready_d = '0;
        wr_ready_d = '0;
        rd_data_d  = rd_data_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c]    = state_q[c];
            owner_d[c]    = owner_q[c];
            is_write_d[c] = is_write_q[c];
            addr_d[c]     = addr_q[c];
            wdata_d[c]    = wdata_q[c];
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                ST_IDLE: begin
                    found = 1'b0;
                    for (int j = 0; j < NUM_CONSUMERS; j++) begin
                        idx = int'(rr_ptr_q) + j;
                        if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                        cand = CW'(idx);
                        if (!found && !busy[cand] && !granted[cand] &&
                            (consumer_read_valid[cand] || wr_req[cand])) begin
                            found         = 1'b1;
                            granted[cand] = 1'b1;
                            owner_d[c]    = cand;
                            rr_ptr_d      = (idx == NUM_CONSUMERS - 1) ? '0 : CW'(idx + 1);
                            // Read wins when a consumer presents both requests.
                            if (consumer_read_valid[cand]) begin
                                state_d[c]    = ST_READ_WAIT;
                                is_write_d[c] = 1'b0;
                                addr_d[c]     = consumer_read_address[idx*ADDR_BITS +: ADDR_BITS];
                            end else begin
                                state_d[c]    = ST_WRITE_WAIT;
                                is_write_d[c] = 1'b1;
                                addr_d[c]     = consumer_write_address[idx*ADDR_BITS +: ADDR_BITS];
                                wdata_d[c]    = consumer_write_data[idx*DATA_BITS +: DATA_BITS];
                            end
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        state_d[c]              = ST_RELEASE;
                        rd_ready_d[owner_q[c]]  = 1'b1;
                        rd_data_d[owner_q[c]*DATA_BITS +: DATA_BITS] =
                            mem_read_data[c*DATA_BITS +: DATA_BITS];
                    end
                end
                ST_WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        state_d[c]             = ST_RELEASE;
                        wr_ready_d[owner_q[c]] = 1'b1;
                    end
                end
                default: begin
                    // Hold ownership until the consumer retires the request it was granted on.
                    if (is_write_q[c] ? !consumer_write_valid[owner_q[c]]
                                      : !consumer_read_valid[owner_q[c]])
                        state_d[c] = ST_IDLE;
                end
            endcase
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem_rv_d[c] = (state_d[c] == ST_READ_WAIT);
            mem_wv_d[c] = (state_d[c] == ST_WRITE_WAIT);
        end
    end

    // All state and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]    <= ST_IDLE;
                owner_q[c]    <= '0;
                is_write_q[c] <= 1'b0;
                addr_q[c]     <= '0;
                wdata_q[c]    <= '0;
            end
            mem_rv_q   <= '0;
            mem_wv_q   <= '0;
            rr_ptr_q   <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rd_data_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]    <= state_d[c];
                owner_q[c]    <= owner_d[c];
                is_write_q[c] <= is_write_d[c];
                addr_q[c]     <= addr_d[c];
                wdata_q[c]    <= wdata_d[c];
            end
            mem_rv_q   <= mem_rv_d;
            mem_wv_q   <= mem_wv_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            rd_data_q  <= rd_data_d;
        end
    end

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan_out
            assign mem_read_address[c*ADDR_BITS +: ADDR_BITS]  = addr_q[c];
            assign mem_write_address[c*ADDR_BITS +: ADDR_BITS] = (WRITE_ENABLE != 0) ? addr_q[c] : '0;
            assign mem_write_data[c*DATA_BITS +: DATA_BITS]    = (WRITE_ENABLE != 0) ? wdata_q[c] : '0;
            assign dbg_chan_state[2*c +: 2]                    = state_q[c];
        end
    endgenerate

    assign mem_read_valid       = mem_rv_q;
    assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_wv_q : '0;
    assign consumer_read_ready  = rd_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_q : '0;
    assign dbg_rr_ptr           = rr_ptr_q;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: directed steps with a read-data scoreboard,
// plus a read-only instance that must never show write activity.
module tb_mem_channel_arbiter;

    localparam int NC = 4;
    localparam int NH = 2;
    localparam int AB = 8;
    localparam int DB = 8;

    logic clk;
    logic rst;
    logic [NC-1:0]    crv, cwv;
    logic [AB*NC-1:0] craddr, cwaddr;
    logic [DB*NC-1:0] cwdata;
    logic [NH-1:0]    mem_rr, mem_wr;
    logic [DB*NH-1:0] mem_rd;

    logic [NC-1:0]    crr, cwr, crr_b, cwr_b;
    logic [DB*NC-1:0] crd, crd_b;
    logic [NH-1:0]    mrv, mwv, mrv_b, mwv_b;
    logic [AB*NH-1:0] maddr, mwaddr, maddr_b, mwaddr_b;
    logic [DB*NH-1:0] mwdata, mwdata_b;
    logic [2*NH-1:0]  dbg_st, dbg_st_b;
    logic [1:0]       rr, rr_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rd_done = 0;
    int n_wr_done = 0;
    logic auto_mem = 1'b0;
    logic [7:0] mem [256];
    logic [9:0] exp_q[$];

    mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                          .NUM_CHANNELS(NH), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(rst),
        .consumer_read_valid(crv), .consumer_read_address(craddr),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(cwv), .consumer_write_address(cwaddr),
        .consumer_write_data(cwdata), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(maddr),
        .mem_read_ready(mem_rr), .mem_read_data(mem_rd),
        .mem_write_valid(mwv), .mem_write_address(mwaddr),
        .mem_write_data(mwdata), .mem_write_ready(mem_wr),
        .dbg_chan_state(dbg_st), .dbg_rr_ptr(rr)
    );

    mem_channel_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                          .NUM_CHANNELS(NH), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(rst),
        .consumer_read_valid(crv), .consumer_read_address(craddr),
        .consumer_read_ready(crr_b), .consumer_read_data(crd_b),
        .consumer_write_valid(cwv), .consumer_write_address(cwaddr),
        .consumer_write_data(cwdata), .consumer_write_ready(cwr_b),
        .mem_read_valid(mrv_b), .mem_read_address(maddr_b),
        .mem_read_ready(mem_rr), .mem_read_data(mem_rd),
        .mem_write_valid(mwv_b), .mem_write_address(mwaddr_b),
        .mem_write_data(mwdata_b), .mem_write_ready(mem_wr),
        .dbg_chan_state(dbg_st_b), .dbg_rr_ptr(rr_b)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: when enabled, completes every request in its first valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_mem) begin
                for (int c = 0; c < NH; c++) begin
                    mem_rr[c] = mrv[c];
                    mem_rd[c*DB +: DB] = mem[maddr[c*AB +: AB]];
                    mem_wr[c] = mwv[c];
                    if (mwv[c]) mem[mwaddr[c*AB +: AB]] = mwdata[c*DB +: DB];
                end
            end
        end
    end

    // Consumer monitor: scores read data against the expected queue and retires requests.
    initial begin
        logic hit;
        int   pos;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < NC; k++) begin
                    if (crr[k]) begin
                        hit = 1'b0;
                        pos = 0;
                        for (int i = 0; i < exp_q.size(); i++) begin
                            if (!hit && exp_q[i][9:8] == 2'(k)) begin
                                hit = 1'b1;
                                pos = i;
                            end
                        end
                        chk($sformatf("rd_expected_c%0d", k), hit, 1'b1);
                        if (hit) begin
                            chk($sformatf("rd_data_c%0d", k), crd[k*DB +: DB], exp_q[pos][7:0]);
                            exp_q.delete(pos);
                        end
                        crv[k] = 1'b0;
                        n_rd_done++;
                    end
                    if (cwr[k]) begin
                        cwv[k] = 1'b0;
                        n_wr_done++;
                    end
                end
            end
        end
    end

    // Directed sequence
    initial begin
        int b;
        int rd_base;
        rst = 1'b1;
        crv = '0; cwv = '0; craddr = '0; cwaddr = '0; cwdata = '0;
        mem_rr = '0; mem_wr = '0; mem_rd = '0;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
        tick();
        tick();
        chk("reset_outputs", {mrv, maddr, mwv, mwaddr, mwdata, crr, crd, cwr, rr, dbg_st}, '0);
        rst = 1'b0;
        tick();

        // Single read, minimum latency, consumer 2
        craddr[2*AB +: AB] = 8'h10;
        crv[2] = 1'b1;
        exp_q.push_back({2'd2, 8'hA5});
        tick();
        chk("single_mem_valid", {mrv, maddr[AB-1:0], crr}, {2'b01, 8'h10, 4'b0000});
        mem_rr[0] = 1'b1;
        mem_rd[DB-1:0] = 8'hA5;
        tick();
        chk("single_ready", {crr, crd[2*DB +: DB], mrv}, {4'b0100, 8'hA5, 2'b00});
        mem_rr[0] = 1'b0;
        tick();
        chk("single_strobe_once", crr, 4'b0000);
        chk("single_data_hold", crd[2*DB +: DB], 8'hA5);
        chk("single_idle_rr", {dbg_st, rr}, {4'b0000, 2'd3});

        // Reset while a read waits on memory
        craddr[1*AB +: AB] = 8'h33;
        crv[1] = 1'b1;
        tick();
        chk("rst_pre_grant", {mrv, maddr[AB-1:0]}, {2'b01, 8'h33});
        rst = 1'b1;
        crv[1] = 1'b0;
        #1;
        chk("rst_mid_outputs", {mrv, maddr, mwv, mwaddr, mwdata, crr, crd, cwr, rr, dbg_st}, '0);
        tick();
        rst = 1'b0;
        mem_rr = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_strobe", {crr, mrv, dbg_st}, '0);
        end
        mem_rr = '0;

        // Contention: all four read at once, two channels
        auto_mem = 1'b1;
        for (int k = 0; k < NC; k++) begin
            craddr[k*AB +: AB] = 8'(32'h20 + k);
            exp_q.push_back({2'(k), mem[8'(32'h20 + k)]});
            crv[k] = 1'b1;
        end
        tick();
        chk("cont_round1", {mrv, maddr, rr}, {2'b11, 8'h21, 8'h20, 2'd2});
        b = 0;
        while (n_rd_done < 3 && b < 20) begin tick(); b++; end
        chk("cont_round1_done", n_rd_done, 3);
        b = 0;
        while (mrv != 2'b11 && b < 10) begin tick(); b++; end
        chk("cont_round2", {mrv, maddr, rr}, {2'b11, 8'h23, 8'h22, 2'd0});
        b = 0;
        while (n_rd_done < 5 && b < 20) begin tick(); b++; end
        chk("cont_all_done", {n_rd_done, exp_q.size()}, {32'd5, 32'd0});
        auto_mem = 1'b0;
        mem_rr = '0;
        mem_wr = '0;
        tick();
        tick();

        // Write from consumer 1, memory stalls four cycles
        cwaddr[1*AB +: AB] = 8'h80;
        cwdata[1*DB +: DB] = 8'h3C;
        cwv[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_held", {mwv, mwaddr[AB-1:0], mwdata[DB-1:0], cwr}, {2'b01, 8'h80, 8'h3C, 4'b0000});
            chk("wr_ro_silent", {mwv_b, mwaddr_b, mwdata_b, cwr_b, mrv_b}, '0);
        end
        mem_wr[0] = 1'b1;
        tick();
        chk("wr_ready", {cwr, mwv}, {4'b0010, 2'b00});
        mem_wr[0] = 1'b0;
        tick();
        chk("wr_strobe_once", {cwr, n_wr_done}, {4'b0000, 32'd1});
        chk("wr_ro_no_write", {cwr_b, mwv_b, dbg_st_b}, '0);
        tick();

        // Stalled read: consumer 3 holds valid, must not take a second channel
        craddr[3*AB +: AB] = 8'h55;
        crv[3] = 1'b1;
        exp_q.push_back({2'd3, 8'h77});
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stall_stable", {mrv, maddr[AB-1:0], dbg_st[3:2]}, {2'b01, 8'h55, 2'b00});
        end
        mem_rr[0] = 1'b1;
        mem_rd[DB-1:0] = 8'h77;
        tick();
        chk("stall_ready", {crr, crd[3*DB +: DB]}, {4'b1000, 8'h77});
        mem_rr[0] = 1'b0;
        tick();
        tick();

        // Read and write together on consumer 0: read first
        auto_mem = 1'b1;
        rd_base = n_rd_done;
        craddr[0 +: AB] = 8'h40;
        cwaddr[0 +: AB] = 8'h41;
        cwdata[0 +: DB] = 8'hC3;
        exp_q.push_back({2'd0, mem[8'h40]});
        crv[0] = 1'b1;
        cwv[0] = 1'b1;
        tick();
        chk("rw_read_first", {mrv, mwv, maddr[AB-1:0]}, {2'b01, 2'b00, 8'h40});
        b = 0;
        while (mwv == 2'b00 && b < 20) begin tick(); b++; end
        chk("rw_write_after", {mwv, mwaddr[AB-1:0], mwdata[DB-1:0]}, {2'b01, 8'h41, 8'hC3});
        chk("rw_read_done_before", n_rd_done, rd_base + 1);
        b = 0;
        while (n_wr_done < 2 && b < 20) begin tick(); b++; end
        chk("rw_write_done", {n_wr_done, mem[8'h41]}, {32'd2, 8'hC3});
        tick();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
